// File: rtl/axi_rd_arb.sv
// -----------------------------------------------------------------------------
// axi_rd_arb
//
// Shares one AXI read master port (AR + R channels) between MST_NUM in-order
// read requesters. The AR channel arbitrates the requesters and registers the
// winner toward the slave. The index of every granted requester is pushed into
// an order FIFO. R beats are then steered to the requester at the FIFO head.
// The slave is assumed to return reads in AR order.
//
// Optional build macro:
//   AXI_RD_ARB_RR_EN  defined   -> round-robin arbitration
//                     undefined -> fixed priority (lowest index wins)
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   m_arvalid  in   [MST_NUM]           per-requester AR valid
//   m_arready  out  [MST_NUM]           per-requester AR ready (one-hot or 0)
//   m_arpld    in   [MST_NUM*AR_PLD_W]  per-requester AR payload, slice i = req i
//   m_rvalid   out  [MST_NUM]           per-requester R valid (one-hot or 0)
//   m_rready   in   [MST_NUM]           per-requester R ready
//   m_rpld     out  [R_PLD_W]           R payload broadcast to all requesters
//   s_arvalid  out                      AR valid to slave
//   s_arready  in                       AR ready from slave
//   s_arpld    out  [AR_PLD_W]          AR payload {id,addr,len,size,burst}
//   s_rvalid   in                       R valid from slave
//   s_rready   out                      R ready to slave
//   s_rpld     in   [R_PLD_W]           R payload {id,data,resp,last}
//   ost_cnt    out  [OST_W+1]           outstanding (granted, no rlast yet)
//   rsp_err    out                      sticky: R beat with nothing outstanding
//
// AR FSM:
//   state | meaning
//   IDLE  | no request toward slave; a requester may be granted and captured
//   REQ   | captured request presented on s_ar*, waiting for s_arready
// -----------------------------------------------------------------------------

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module axi_rd_arb #(
    parameter int MST_NUM  = 2,
    parameter int MST_W    = 1,
    parameter int OST_NUM  = 8,
    parameter int OST_W    = 3,
    parameter int AR_PLD_W = `AXI_ID_WIDTH + `AXI_ADDR_WIDTH + `AXI_LEN_WIDTH
                           + `AXI_SIZE_WIDTH + `AXI_BURST_WIDTH,
    parameter int R_PLD_W  = `AXI_ID_WIDTH + `AXI_DATA_WIDTH + `AXI_RESP_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [MST_NUM-1:0]           m_arvalid,
    output logic [MST_NUM-1:0]           m_arready,
    input  logic [MST_NUM*AR_PLD_W-1:0]  m_arpld,
    output logic [MST_NUM-1:0]           m_rvalid,
    input  logic [MST_NUM-1:0]           m_rready,
    output logic [R_PLD_W-1:0]           m_rpld,
    output logic                         s_arvalid,
    input  logic                         s_arready,
    output logic [AR_PLD_W-1:0]          s_arpld,
    input  logic                         s_rvalid,
    output logic                         s_rready,
    input  logic [R_PLD_W-1:0]           s_rpld,
    output logic [OST_W:0]               ost_cnt,
    output logic                         rsp_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                state_q, state_d;

    logic [MST_W-1:0]      fifo_mem [OST_NUM];
    logic [OST_W-1:0]      wr_ptr, rd_ptr;
    logic [OST_W:0]        cnt_q;
    logic                  fifo_empty, fifo_full;

    logic                  any_req;
    logic                  capture;
    logic                  pop;
    logic                  r_last;
    logic [MST_W-1:0]      grant_idx;
    logic [MST_W-1:0]      head_idx;
    logic [AR_PLD_W-1:0]   ar_pld_q;
    logic                  err_q;

    // The counter tracks FIFO occupancy exactly (push on capture, pop on
    // rlast), so it doubles as the empty/full indication.
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == (OST_W+1)'(OST_NUM));
    assign any_req    = |m_arvalid;
    assign head_idx   = fifo_mem[rd_ptr];
    assign r_last     = s_rpld[0];

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
`ifdef AXI_RD_ARB_RR_EN
    logic [MST_W-1:0] rr_ptr;

    // Pick the valid requester with the smallest rotational distance from
    // the round-robin pointer.
    always_comb begin
        int best;
        int dist;
        grant_idx = '0;
        best      = MST_NUM;
        dist      = 0;
        for (int i = 0; i < MST_NUM; i++) begin
            dist = (i - int'(rr_ptr) + MST_NUM) % MST_NUM;
            if (m_arvalid[i] && (dist < best)) begin
                best      = dist;
                grant_idx = MST_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (capture) begin
            rr_ptr <= (grant_idx == MST_W'(MST_NUM - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    always_comb begin
        grant_idx = '0;
        for (int i = MST_NUM - 1; i >= 0; i--) begin
            if (m_arvalid[i]) begin
                grant_idx = MST_W'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // AR FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Full uses the registered count, so a pop in the same cycle does not
    // open the gate until the following cycle. rst_n gates the ready so that
    // a requester never sees a handshake while the block is held in reset.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        m_arready = '0;
        case (state_q)
            IDLE: begin
                if (rst_n && any_req && !fifo_full) begin
                    capture              = 1'b1;
                    m_arready[grant_idx] = 1'b1;
                    state_d              = REQ;
                end
            end
            REQ: begin
                if (s_arready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_pld_q <= '0;
        end else if (capture) begin
            ar_pld_q <= m_arpld[int'(grant_idx)*AR_PLD_W +: AR_PLD_W];
        end
    end

    assign s_arvalid = (state_q == REQ);
    assign s_arpld   = ar_pld_q;

    // ------------------------------------------------------------------
    // Order FIFO
    // ------------------------------------------------------------------
    // Storage is not reset; entries are only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= (wr_ptr == OST_W'(OST_NUM - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == OST_W'(OST_NUM - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            case ({capture, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign ost_cnt = cnt_q;

    // ------------------------------------------------------------------
    // R routing
    // ------------------------------------------------------------------
    always_comb begin
        m_rvalid = '0;
        s_rready = 1'b0;
        if (!fifo_empty) begin
            m_rvalid[head_idx] = s_rvalid;
            s_rready           = m_rready[head_idx];
        end
    end

    assign m_rpld = s_rpld;
    assign pop    = s_rvalid & s_rready & r_last;

    // A beat with nothing outstanding is never accepted; flag it until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (s_rvalid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;

endmodule

// File: doc/axi_rd_arb.md
Name: axi_rd_arb

Overview:
- Shares one AXI read master port (AR + R channels) between MST_NUM in-order read requesters, e.g. IFU instruction fetch on index 0 and LSU load path on index 1.
- Arbitrates AR requests and registers the granted request toward the slave.
- Records each grant's source in an order FIFO and routes R beats back to the owning requester.
- Sits between the core fetch/load units and the AXI interconnect; the slave returns reads in AR order.

Parameters:
- MST_NUM, 2, number of requesters (legal 2..4).
- MST_W, 1, width of a requester index; ceil(log2(MST_NUM)).
- OST_NUM, 8, maximum outstanding AR transactions (order FIFO depth).
- OST_W, 3, log2(OST_NUM).
- AR_PLD_W, `AXI_ID_WIDTH+`AXI_ADDR_WIDTH+`AXI_LEN_WIDTH+`AXI_SIZE_WIDTH+`AXI_BURST_WIDTH, packed AR payload {id,addr,len,size,burst}.
- R_PLD_W, `AXI_ID_WIDTH+`AXI_DATA_WIDTH+`AXI_RESP_WIDTH+1, packed R payload {id,data,resp,last}.

Ports:
- clk  in  1  clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- m_arvalid  in  MST_NUM  per-requester AR valid.
- m_arready  out  MST_NUM  per-requester AR ready; at most one bit set.
- m_arpld  in  MST_NUM*AR_PLD_W  per-requester AR payload; requester i occupies slice i.
- m_rvalid  out  MST_NUM  per-requester R valid; at most one bit set.
- m_rready  in  MST_NUM  per-requester R ready.
- m_rpld  out  R_PLD_W  R payload broadcast to all requesters.
- s_arvalid  out  1  AR valid to slave.
- s_arready  in  1  AR ready from slave.
- s_arpld  out  AR_PLD_W  AR payload to slave.
- s_rvalid  in  1  R valid from slave.
- s_rready  out  1  R ready to slave.
- s_rpld  in  R_PLD_W  R payload from slave.
- ost_cnt  out  OST_W+1  outstanding transactions: granted and not yet completed by an rlast beat.
- rsp_err  out  1  sticky; an R beat arrived with no outstanding transaction.

Behaviour:
- Reset (asynchronous, any cycle including mid-burst):
  - s_arvalid=0, s_arpld=0, m_arready=0, m_rvalid=0, s_rready=0.
  - ost_cnt=0, rsp_err=0, order FIFO empty, round-robin pointer=0, FSM=IDLE.
  - In-flight responses are discarded; the system resets the slave at the same time.
- AR FSM has 2 states:
  - IDLE: s_arvalid=0. If any m_arvalid is set and ost_cnt<OST_NUM, the arbiter picks winner g. m_arready[g]=1 combinationally in that cycle. On that edge: m_arpld slice g is captured into s_arpld, g is pushed to the order FIFO, FSM->REQ.
  - REQ: s_arvalid=1, payload held stable, all m_arready=0. On s_arready=1: FSM->IDLE.
  - Latency: requester handshake at cycle n gives s_arvalid at n+1. Peak rate is 1 AR per 2 cycles.
- Full: ost_cnt==OST_NUM blocks capture. A pop in the same cycle does not unblock it; capture can occur from the next cycle.
- Default arbitration is fixed priority: the lowest set index of m_arvalid wins. Requester 0 starves the others while it requests continuously.
- R routing (combinational, no added latency):
  - h = head of the order FIFO.
  - m_rvalid[h] = s_rvalid & ~empty.
  - s_rready = m_rready[h] & ~empty.
  - m_rpld = s_rpld.
  - Pop happens on s_rvalid & s_rready & rlast. Non-last beats do not pop.
- Empty FIFO with s_rvalid=1: s_rready=0, no m_rvalid, and rsp_err is set and stays set until reset.
- ost_cnt increments on capture and decrements on pop. Simultaneous capture and pop leaves it unchanged. It never exceeds OST_NUM.
- Order FIFO: circular buffer of OST_NUM entries × MST_W bits. Read and write pointers wrap modulo OST_NUM.
- The arbiter never inspects or modifies IDs. Each requester receives its own responses in issue order.

Optional Feature:
- Macro AXI_RD_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at the round-robin pointer and wraps through MST_NUM.
  - On every capture the pointer becomes (g+1) mod MST_NUM.
  - With all requesters continuously valid, grants rotate 0,1,..,MST_NUM-1.
- Undefined: fixed priority as described in Behaviour; the pointer logic is not built.

Test Plan:
- Single requester: m_arvalid[0]=1, addr 0x100, len 0; slave s_arready=1 -> s_arvalid at n+1 with addr 0x100, ost_cnt=1. One R beat with last=1 -> m_rvalid[0]=1, ost_cnt=0.
- Contention: m0 and m1 both valid for 4 grants -> fixed priority gives the grant order 0,0,0,0. With AXI_RD_ARB_RR_EN the order is 0,1,0,1.
- Ordering: m1 issues a len=3 burst, then m0 issues len=0 -> 4 beats go to m_rvalid[1] only, then 1 beat to m_rvalid[0]. No beat on m0 before m1's rlast.
- Full: s_arready=1, no R responses, m0 continuously valid -> exactly 8 captures, ost_cnt=8, m_arready stays 0. One rlast beat -> the next capture occurs the following cycle.
- Backpressure: m_rready[h]=0 for 3 cycles with s_rvalid=1 -> s_rready=0 for those cycles, payload is not lost, and ost_cnt is unchanged.
- Error and reset: s_rvalid=1 with ost_cnt=0 -> rsp_err=1 and stays set. Asserting rst_n=0 mid-burst -> all outputs return to their reset values asynchronously, and rsp_err=0.
